// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB write arbiter.
// The optional round-robin tie-break in sccb_arbiter is enabled with SCCB_ARB_RR_EN.
package sccb_arb_pkg;

   localparam int REQ_W = 24;
   localparam int ENG_W = 32;
   localparam int CNT_W = 22;

   localparam logic [7:0] DEF_DEV_ADDR    = 8'hC0;
   localparam int         DEF_TIMEOUT_CYC = 2_400_000;
   localparam int         DEF_GAP_CYC     = 2400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_END,
      ST_RELEASE,
      ST_GAP
   } arb_state_e;

   // Engine word: device write address followed by {reg_addr, reg_val}.
   function automatic logic [ENG_W-1:0] pack_word(input logic [7:0] dev_addr,
                                                  input logic [REQ_W-1:0] req_word);
      return {dev_addr, req_word};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from the I2C engine clock domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_24M,
   input  logic             camera_rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk_24M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/sccb_arbiter.sv
// Two-requester arbiter in front of a single SCCB/I2C write engine, with timeout and inter-transfer gap.
// Define SCCB_ARB_RR_EN to make simultaneous requests alternate instead of favouring requester 0.
module sccb_arbiter
   import sccb_arb_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR    = DEF_DEV_ADDR,
   parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int         GAP_CYC     = DEF_GAP_CYC
) (
   input  logic             clk_24M,
   input  logic             camera_rstn,
   input  logic             req0_valid,
   input  logic [REQ_W-1:0] req0_data,
   output logic             req0_ready,
   output logic             req0_done,
   output logic             req0_err,
   input  logic             req1_valid,
   input  logic [REQ_W-1:0] req1_data,
   output logic             req1_ready,
   output logic             req1_done,
   output logic             req1_err,
   output logic             eng_start,
   output logic [ENG_W-1:0] eng_data,
   input  logic             eng_tr_end,
   input  logic             eng_ack,
   output logic             busy,
   output logic             grant
);

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

   arb_state_e       state_reg, state_next;
   logic [ENG_W-1:0] eng_data_reg, eng_data_next;
   logic             eng_start_reg, eng_start_next;
   logic             grant_reg, grant_next;
   logic [1:0]       ready_reg, ready_next;
   logic [1:0]       done_reg, done_next;
   logic [1:0]       err_reg, err_next;
   logic [CNT_W-1:0] to_cnt_reg, to_cnt_next;
   logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic             tr_end_prev_reg;

   logic [1:0] sync_q;
   logic       tr_end_s;
   logic       ack_s;
   logic       tr_end_rise;
   logic       accept;
   logic       pick1;

   sync_2ff #(
      .WIDTH(2)
   ) u_sync (
      .clk_24M     (clk_24M),
      .camera_rstn (camera_rstn),
      .d           ({eng_tr_end, eng_ack}),
      .q           (sync_q)
   );

   assign tr_end_s    = sync_q[1];
   assign ack_s       = sync_q[0];
   assign tr_end_rise = tr_end_s & ~tr_end_prev_reg;
   assign accept      = (state_reg == ST_IDLE) & (req0_valid | req1_valid);

`ifdef SCCB_ARB_RR_EN
   // Remembers who was served last; a tie goes to the other requester.
   logic last_grant_reg;

   always_ff @(posedge clk_24M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         last_grant_reg <= 1'b0;
      end else if (accept) begin
         last_grant_reg <= pick1;
      end
   end

   assign pick1 = req1_valid & (~req0_valid | ~last_grant_reg);
`else
   assign pick1 = req1_valid & ~req0_valid;
`endif

   always_ff @(posedge clk_24M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         state_reg       <= ST_IDLE;
         eng_data_reg    <= '0;
         eng_start_reg   <= 1'b0;
         grant_reg       <= 1'b0;
         ready_reg       <= '0;
         done_reg        <= '0;
         err_reg         <= '0;
         to_cnt_reg      <= '0;
         gap_cnt_reg     <= '0;
         tr_end_prev_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         eng_data_reg    <= eng_data_next;
         eng_start_reg   <= eng_start_next;
         grant_reg       <= grant_next;
         ready_reg       <= ready_next;
         done_reg        <= done_next;
         err_reg         <= err_next;
         to_cnt_reg      <= to_cnt_next;
         gap_cnt_reg     <= gap_cnt_next;
         tr_end_prev_reg <= tr_end_s;
      end
   end

   always_comb begin
      state_next     = state_reg;
      eng_data_next  = eng_data_reg;
      eng_start_next = eng_start_reg;
      grant_next     = grant_reg;
      ready_next     = '0;
      done_next      = '0;
      err_next       = '0;
      to_cnt_next    = to_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               grant_next        = pick1;
               ready_next[pick1] = 1'b1;
               eng_data_next     = pack_word(DEV_ADDR, pick1 ? req1_data : req0_data);
               state_next        = ST_START;
            end
         end

         ST_START: begin
            eng_start_next = 1'b1;
            to_cnt_next    = '0;
            state_next     = ST_WAIT_END;
         end

         ST_WAIT_END: begin
            to_cnt_next = to_cnt_reg + 1'b1;
            if (tr_end_rise) begin
               eng_start_next      = 1'b0;
               done_next[grant_reg] = 1'b1;
               err_next[grant_reg]  = ack_s;
               state_next          = ST_RELEASE;
            end else if (to_cnt_reg == TO_LAST) begin
               eng_start_next      = 1'b0;
               done_next[grant_reg] = 1'b1;
               err_next[grant_reg]  = 1'b1;
               gap_cnt_next        = '0;
               state_next          = ST_GAP;
            end
         end

         // done/err already reported here, so a timeout only moves on silently.
         ST_RELEASE: begin
            to_cnt_next = to_cnt_reg + 1'b1;
            if (!tr_end_s || (to_cnt_reg == TO_LAST)) begin
               gap_cnt_next = '0;
               state_next   = ST_GAP;
            end
         end

         ST_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   assign req0_ready = ready_reg[0];
   assign req1_ready = ready_reg[1];
   assign req0_done  = done_reg[0];
   assign req1_done  = done_reg[1];
   assign req0_err   = err_reg[0];
   assign req1_err   = err_reg[1];
   assign eng_start  = eng_start_reg;
   assign eng_data   = eng_data_reg;
   assign grant      = grant_reg;
   assign busy       = (state_reg != ST_IDLE);

endmodule
